// File: rtl/cpu_intc.sv
// cpu_intc: four-source interrupt controller for the 8-bit cpu core.
// Edge-detects ie1..ie4, latches pending requests, applies an enable mask,
// picks by fixed priority (bit 0 highest) and runs a req/ack/ret handshake.
module cpu_intc #(
  parameter int unsigned          VEC_W    = 10,
  parameter logic [VEC_W-1:0]     VEC_BASE = VEC_W'(10'h3F0)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       irq_in,
  input  logic             mask_we,
  input  logic [3:0]       mask_wd,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [1:0]       int_id,
  output logic             in_service,
  output logic [3:0]       pend,
  output logic [3:0]       mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] irq_q;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [3:0] pend_n;
  logic [1:0] id_n;
  logic       found;

  // Next-state, priority pick and pending-set/clear decode
  always_comb begin
    state_n  = state;
    id_n     = int_id;
    clr      = '0;
    found    = 1'b0;
    rise     = irq_in & ~irq_q;
    eligible = pend & mask;
    case (state)
      IDLE: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (eligible[i] && !found) begin
            id_n  = 2'(i);
            found = 1'b1;
          end
        end
        if (found) state_n = REQ;
      end
      REQ: begin
        if (int_ack) begin
          clr[int_id] = 1'b1;
          state_n     = SERVICE;
        end
      end
      SERVICE: begin
        if (int_ret) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A new edge on the bit being acknowledged is kept (set wins)
    pend_n = (pend & ~clr) | rise;
  end

  // State register and committed source index
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      int_id <= '0;
    end else begin
      state  <= state_n;
      int_id <= id_n;
    end
  end

  // Pending and mask registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= pend_n;
      if (mask_we) mask <= mask_wd;
    end
  end

  // Edge-detect history; keeps tracking the pins during reset so that
  // lines already high when reset releases do not raise events.
  always_ff @(posedge clk) begin
    irq_q <= irq_in;
  end

  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);
  assign int_vec    = VEC_BASE + VEC_W'(int_id);

endmodule

// File: tb/tb_cpu_intc.sv
// Testbench for cpu_intc: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the controller.
module tb_cpu_intc;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       int_ack;
  logic       int_ret;
  logic       int_req;
  logic [9:0] int_vec;
  logic [1:0] int_id;
  logic       in_service;
  logic [3:0] pend;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = waiting, 1 = requesting, 2 = handler running
  bit [3:0] m_pend;
  bit [3:0] m_mask;
  bit [3:0] m_prev;
  int       m_mode;
  int       m_id;

  cpu_intc #(.VEC_W(10), .VEC_BASE(10'h3F0)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .in_service (in_service),
    .pend       (pend),
    .mask       (mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit [3:0] old_pend;
    bit [3:0] old_mask;
    int       pick;
    if (!reset) begin
      m_pend = '0;
      m_mask = '0;
      m_mode = 0;
      m_id   = 0;
    end else begin
      old_pend = m_pend;
      old_mask = m_mask;
      if (m_mode == 1 && int_ack) m_pend[m_id] = 1'b0;
      for (int i = 0; i < 4; i++)
        if (irq_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
      case (m_mode)
        0: begin
          pick = -1;
          for (int i = 3; i >= 0; i--)
            if (old_pend[i] && old_mask[i]) pick = i;
          if (pick >= 0) begin
            m_id   = pick;
            m_mode = 1;
          end
        end
        1: if (int_ack) m_mode = 2;
        default: if (int_ret) m_mode = 0;
      endcase
      if (mask_we) m_mask = mask_wd;
    end
    m_prev = irq_in;
  endtask

  task automatic compare_all();
    check("int_req",    32'(int_req),    32'(m_mode == 1));
    check("in_service", 32'(in_service), 32'(m_mode == 2));
    check("int_id",     32'(int_id),     32'(m_id));
    check("int_vec",    32'(int_vec),    32'((1008 + m_id) % 1024));
    check("pend",       32'(pend),       32'(m_pend));
    check("mask",       32'(mask),       32'(m_mask));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic [3:0] irq, input logic we,
                       input logic [3:0] wd, input logic ack, input logic ret);
    reset   = r;
    irq_in  = irq;
    mask_we = we;
    mask_wd = wd;
    int_ack = ack;
    int_ret = ret;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},  32'(int_req),    32'h0);
    check({tag, "_svc"},  32'(in_service), 32'h0);
    check({tag, "_pend"}, 32'(pend),       32'h0);
    check({tag, "_mask"}, 32'(mask),       32'h0);
    check({tag, "_id"},   32'(int_id),     32'h0);
    check({tag, "_vec"},  32'(int_vec),    32'h3F0);
  endtask

  initial begin
    drive(1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);

    // Reset with all lines high, then release while they stay high
    tick(); tick();
    check_reset_values("rst");
    drive(1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (3) tick();
    check("held_high_pend", 32'(pend), 32'h0);
    check("held_high_req",  32'(int_req), 32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();

    // Single source
    drive(1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("single_pend", 32'(pend), 32'h4);
    check("single_req_early", 32'(int_req), 32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("single_req", 32'(int_req), 32'h1);
    check("single_id",  32'(int_id),  32'h2);
    check("single_vec", 32'(int_vec), 32'h3F2);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    check("single_svc",  32'(in_service), 32'h1);
    check("single_pclr", 32'(pend), 32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();
    check("single_ret", 32'(in_service), 32'h0);

    // Priority: sources 3 and 0 together
    drive(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("prio_first_vec", 32'(int_vec), 32'h3F0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();
    check("prio_idle_gap", 32'(int_req), 32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("prio_second_vec", 32'(int_vec), 32'h3F3);
    check("prio_second_req", 32'(int_req), 32'h1);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();

    // Masking
    drive(1'b1, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mask_hold_req",  32'(int_req), 32'h0);
      check("mask_hold_pend", 32'(pend),    32'h1);
    end
    drive(1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0); tick();
    check("mask_write_req", 32'(int_req), 32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("unmask_req", 32'(int_req), 32'h1);
    check("unmask_id",  32'(int_id),  32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();

    // Events and stray ack during service
    drive(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    check("svc_req",  32'(int_req),    32'h0);
    check("svc_busy", 32'(in_service), 32'h1);
    check("svc_pend", 32'(pend),       32'h1);
    check("svc_id",   32'(int_id),     32'h1);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("after_svc_req", 32'(int_req), 32'h1);
    check("after_svc_id",  32'(int_id),  32'h0);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();

    // Set/clear collision on the acknowledged bit
    drive(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h2, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    check("collide_pend", 32'(pend),       32'h2);
    check("collide_svc",  32'(in_service), 32'h1);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("collide_rereq", 32'(int_id), 32'h1);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1); tick();

    // Reset in REQ, then in SERVICE
    drive(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("pre_rst_req", 32'(int_req), 32'h1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check_reset_values("rst_req");
    drive(1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("pre_rst_svc", 32'(in_service), 32'h1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1); tick();
    check_reset_values("rst_svc");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0),
            4'($urandom & $urandom & $urandom),
            ($urandom_range(0, 7) == 0),
            4'($urandom),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
